// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: command/status bus between the controlling logic and the PS/2 host transmitter
// Signals:
//   tx_data     command byte to send
//   tx_valid    send request, taken when tx_ready is high
//   tx_ready    transmitter idle and able to take a byte
//   busy        transfer in progress
//   done        one-cycle pulse: byte sent and acknowledged
//   err_noack   one-cycle pulse: device did not acknowledge
//   err_timeout one-cycle pulse: device stopped clocking
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       err_noack;
  logic       err_timeout;
  modport master (output tx_data, tx_valid, input tx_ready, busy, done, err_noack, err_timeout);
  modport slave  (input tx_data, tx_valid, output tx_ready, busy, done, err_noack, err_timeout);
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter (inhibit, request-to-send, 8 data + odd parity + stop, ACK)
// Ports:
//   sys_clk     system clock
//   reset       asynchronous active-low reset
//   host        command/status bus (slave side)
//   ps2_clk_in  raw PS/2 clock pin level (asynchronous)
//   ps2_dat_in  raw PS/2 data pin level (asynchronous)
//   ps2_clk_oe  1 = pull PS/2 clock low, 0 = release
//   ps2_dat_oe  1 = pull PS/2 data low, 0 = release
module ps2_host_tx #(
  parameter int INHIBIT_CYC = 6000,
  parameter int TIMEOUT_CYC = 750000,
  parameter int CNT_W       = 20
) (
  input  logic              sys_clk,
  input  logic              reset,
  ps2_host_tx_if.slave      host,
  input  logic              ps2_clk_in,
  input  logic              ps2_dat_in,
  output logic              ps2_clk_oe,
  output logic              ps2_dat_oe
);
  typedef enum logic [2:0] {IDLE, INHIBIT, RTS, SEND, ACK, WAIT_IDLE} state_t;
  localparam logic [CNT_W-1:0] INH_T = CNT_W'(INHIBIT_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_T = CNT_W'(TIMEOUT_CYC - 1);
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0] k, k_n;
  logic [7:0] shreg, shreg_n;
  logic par, par_n;
  logic clk_oe_n, dat_oe_n, done_q, done_n, noack_q, noack_n, tmo_q, tmo_n;
  logic [1:0] clk_s, dat_s;
  logic clk_h, fall, tmo;
  assign fall = clk_h & ~clk_s[1];
  assign tmo = cnt == TMO_T;
  assign host.tx_ready = state == IDLE;
  assign host.busy = state != IDLE;
  assign host.done = done_q;
  assign host.err_noack = noack_q;
  assign host.err_timeout = tmo_q;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    k_n = k;
    shreg_n = shreg;
    par_n = par;
    clk_oe_n = ps2_clk_oe;
    dat_oe_n = ps2_dat_oe;
    done_n = 1'b0;
    noack_n = 1'b0;
    tmo_n = 1'b0;
    case (state)
      IDLE: if (host.tx_valid) begin
        state_n = INHIBIT;
        cnt_n = '0;
        k_n = '0;
        shreg_n = host.tx_data;
        par_n = ~^host.tx_data;
        clk_oe_n = 1'b1;
      end
      INHIBIT: if (cnt == INH_T) begin
        state_n = RTS;
        cnt_n = '0;
        clk_oe_n = 1'b0;
        dat_oe_n = 1'b1;
      end else cnt_n = cnt + 1'b1;
      default: begin
        // from clock release onward the counter measures the timeout window and saturates
        cnt_n = tmo ? cnt : cnt + 1'b1;
        if (tmo) begin
          state_n = IDLE;
          clk_oe_n = 1'b0;
          dat_oe_n = 1'b0;
          tmo_n = 1'b1;
        end else case (state)
          RTS: begin
            state_n = SEND;
            k_n = '0;
          end
          SEND: if (fall) begin
            dat_oe_n = (k == 4'd8) ? ~par : (k == 4'd9) ? 1'b0 : ~shreg[k[2:0]];
            k_n = k + 1'b1;
            state_n = (k == 4'd9) ? ACK : SEND;
          end
          ACK: if (fall) begin
            noack_n = dat_s[1];
            state_n = dat_s[1] ? IDLE : WAIT_IDLE;
          end
          WAIT_IDLE: if (clk_s[1] & dat_s[1]) begin
            done_n = 1'b1;
            state_n = IDLE;
          end
          default: state_n = IDLE;
        endcase
      end
    endcase
  end
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      k <= '0;
      shreg <= '0;
      par <= 1'b0;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
      done_q <= 1'b0;
      noack_q <= 1'b0;
      tmo_q <= 1'b0;
      clk_s <= 2'b11;
      dat_s <= 2'b11;
      clk_h <= 1'b1;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      k <= k_n;
      shreg <= shreg_n;
      par <= par_n;
      ps2_clk_oe <= clk_oe_n;
      ps2_dat_oe <= dat_oe_n;
      done_q <= done_n;
      noack_q <= noack_n;
      tmo_q <= tmo_n;
      clk_s <= {clk_s[0], ps2_clk_in};
      dat_s <= {dat_s[0], ps2_dat_in};
      clk_h <= clk_s[1];
    end
  end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench for ps2_host_tx with a PS/2 device model and result scoreboard
module tb_ps2_host_tx;
  localparam int INH = 600;
  localparam int TMO = 3000;
  localparam int HALF = 40;
  logic sys_clk = 1'b0;
  logic reset = 1'b1;
  logic dev_clk = 1'b1;
  logic dev_dat = 1'b1;
  logic ps2_clk_in, ps2_dat_in, ps2_clk_oe, ps2_dat_oe;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int t_acc = 0;
  bit exp_q[$];
  logic [6:0] res_q[$];
  logic [6:0] got_q[$];
  logic pend = 1'b0;
  logic [3:0] pend_w = '0;
  ps2_host_tx_if bus();
  assign ps2_clk_in = ~ps2_clk_oe & dev_clk;
  assign ps2_dat_in = ~ps2_dat_oe & dev_dat;
  ps2_host_tx #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TMO)) dut (
    .sys_clk(sys_clk),
    .reset(reset),
    .host(bus),
    .ps2_clk_in(ps2_clk_in),
    .ps2_dat_in(ps2_dat_in),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe)
  );
  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;
  // each result pulse is logged as {busy,done,noack,timeout} at the pulse plus {ready,clk_oe,dat_oe} one cycle later
  always @(negedge sys_clk) begin
    if (pend) got_q.push_back({pend_w, bus.tx_ready, ps2_clk_oe, ps2_dat_oe});
    pend <= reset && (bus.done || bus.err_noack || bus.err_timeout);
    pend_w <= {bus.busy, bus.done, bus.err_noack, bus.err_timeout};
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [7:0] d, input logic [2:0] res);
    @(negedge sys_clk);
    check("ready_before_send", 32'(bus.tx_ready), 1);
    bus.tx_data = d;
    bus.tx_valid = 1'b1;
    @(negedge sys_clk);
    bus.tx_valid = 1'b0;
    t_acc = cyc;
    check("busy_ready_after_accept", 32'({bus.busy, bus.tx_ready}), 2);
    for (int i = 0; i < 8; i++) exp_q.push_back(~d[i]);
    exp_q.push_back(^d);
    exp_q.push_back(1'b0);
    if (res != 3'b000) res_q.push_back({1'b0, res, 3'b100});
  endtask
  task automatic wait_rts();
    int n = 0;
    while (!(ps2_dat_oe && !ps2_clk_oe) && n < INH + 100) begin
      @(negedge sys_clk);
      n++;
    end
  endtask
  task automatic device(input int nfalls, input bit ack_low);
    wait_rts();
    check("inhibit_len", cyc - t_acc, INH);
    repeat (10) @(negedge sys_clk);
    for (int i = 1; i <= nfalls; i++) begin
      bit e;
      dev_clk = 1'b0;
      if (i == 11) dev_dat = ~ack_low;
      repeat (HALF) @(negedge sys_clk);
      if (i <= 10) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
        check($sformatf("dat_oe_fall%0d", i), 32'(ps2_dat_oe), 32'(e));
      end
      if (i == nfalls && nfalls < 11) return;
      dev_clk = 1'b1;
      repeat (HALF) @(negedge sys_clk);
    end
    dev_dat = 1'b1;
  endtask
  task automatic check_result(input string tag);
    int n = 0;
    while (got_q.size() == 0 && n < 2000) begin
      @(negedge sys_clk);
      n++;
    end
    check({tag, "_seen"}, 32'(got_q.size() > 0), 1);
    if (got_q.size() > 0 && res_q.size() > 0) check(tag, 32'(got_q.pop_front()), 32'(res_q.pop_front()));
  endtask
  initial begin
    int n;
    bus.tx_data = '0;
    bus.tx_valid = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge sys_clk);
    check("rst_ready_busy", 32'({bus.tx_ready, bus.busy}), 2);
    check("rst_oe", 32'({ps2_clk_oe, ps2_dat_oe}), 0);
    check("rst_pulses", 32'({bus.done, bus.err_noack, bus.err_timeout}), 0);
    reset = 1'b1;
    repeat (3) @(negedge sys_clk);
    send(8'hED, 3'b100);
    device(11, 1'b1);
    check_result("done_ed");
    send(8'h00, 3'b100);
    device(11, 1'b1);
    check_result("done_00");
    send(8'hFF, 3'b100);
    device(11, 1'b1);
    check_result("done_ff");
    send(8'hF4, 3'b010);
    device(11, 1'b0);
    check_result("noack");
    send(8'hF4, 3'b001);
    exp_q.delete();
    wait_rts();
    n = 0;
    while (!bus.err_timeout && n < TMO + 100) begin
      @(negedge sys_clk);
      n++;
    end
    check("timeout_cycles", n, TMO);
    check("timeout_oe", 32'({ps2_clk_oe, ps2_dat_oe}), 0);
    check_result("timeout");
    send(8'hF4, 3'b000);
    device(4, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("async_rst_oe", 32'({ps2_clk_oe, ps2_dat_oe}), 0);
    check("async_rst_ready_busy", 32'({bus.tx_ready, bus.busy}), 2);
    exp_q.delete();
    dev_clk = 1'b1;
    @(negedge sys_clk);
    reset = 1'b1;
    repeat (5) @(negedge sys_clk);
    send(8'hF4, 3'b100);
    device(11, 1'b1);
    check_result("done_f4_after_reset");
    send(8'hED, 3'b100);
    repeat (5) @(negedge sys_clk);
    bus.tx_data = 8'h55;
    bus.tx_valid = 1'b1;
    @(negedge sys_clk);
    check("ready_while_busy", 32'(bus.tx_ready), 0);
    bus.tx_valid = 1'b0;
    device(11, 1'b1);
    check_result("done_ed_ignore");
    repeat (50) @(negedge sys_clk);
    check("no_extra_results", got_q.size(), 0);
    check("no_pending_bits", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. It sends command bytes to the keyboard, e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset.
- It is the transmit counterpart of the keyboard scan-code receiver. It shares the same ps2_clk/ps2_dat lines through open-drain enables resolved at the top level.
- It runs entirely on sys_clk. The PS/2 pins are treated as asynchronous inputs.
- It reports completion, a missing device ACK, or a timeout to the controlling logic. While busy is high, the receiver ignores the line.

Parameters:
- INHIBIT_CYC, 6000, sys_clk cycles the clock line is held low before the request-to-send (120 us at 50 MHz).
- TIMEOUT_CYC, 750000, maximum sys_clk cycles from releasing the clock to line-idle before aborting (15 ms at 50 MHz).
- CNT_W, 20, width of the shared cycle counter. Must satisfy 2^CNT_W > max(INHIBIT_CYC, TIMEOUT_CYC).

Ports:
- sys_clk  in  1  system clock (50 MHz)
- reset  in  1  asynchronous, active-low reset
- tx_data  in  8  command byte to send
- tx_valid  in  1  request; accepted when tx_valid & tx_ready on a rising sys_clk edge
- tx_ready  out  1  high only in IDLE
- ps2_clk_in  in  1  raw PS/2 clock pin level
- ps2_dat_in  in  1  raw PS/2 data pin level
- ps2_clk_oe  out  1  1 = drive PS/2 clock low; 0 = release (high-Z)
- ps2_dat_oe  out  1  1 = drive PS/2 data low; 0 = release (high-Z)
- busy  out  1  high from acceptance until return to IDLE
- done  out  1  one-cycle pulse: byte sent and device ACK received
- err_noack  out  1  one-cycle pulse: device did not pull data low at the ACK bit
- err_timeout  out  1  one-cycle pulse: TIMEOUT_CYC expired

Behaviour:
- Reset values:
  - tx_ready=1; busy=0.
  - ps2_clk_oe=0 and ps2_dat_oe=0; both lines are released immediately on reset assertion, including mid-transfer.
  - done, err_noack, err_timeout = 0; counter=0; bit index=0; state=IDLE.
- Input synchronisation and edge detect:
  - ps2_clk_in and ps2_dat_in each pass through 2 flops, then one more history flop.
  - fall = prev & ~cur on the synchronised clock. Effective latency is 3 sys_clk.
- Acceptance:
  - Latch tx_data into shreg and compute par = ~^tx_data (odd parity).
  - tx_ready drops the next cycle. tx_valid is ignored while not in IDLE.
- IDLE: both oe=0. On accept, go to INHIBIT and clear the counter.
- INHIBIT:
  - clk_oe=1; the counter increments every cycle.
  - When counter==INHIBIT_CYC-1, set dat_oe=1 (start bit) and go to RTS.
- RTS:
  - clk_oe=0, dat_oe=1. The counter is cleared on entry and from here on counts toward TIMEOUT_CYC.
  - Go to SEND with bit index k=0.
- SEND, on each fall:
  - k=0..7: dat_oe = ~shreg[k], LSB first.
  - k=8: dat_oe = ~par.
  - k=9: dat_oe=0 (stop bit released).
  - k increments after each fall. After the k=9 fall, go to ACK.
  - Between falls, dat_oe holds its value.
- ACK: on the next fall, sample synchronised data.
  - 0 → go to WAIT_IDLE.
  - 1 → pulse err_noack, go to IDLE.
- WAIT_IDLE:
  - When synchronised clock=1 and data=1 for 1 cycle, pulse done and go to IDLE.
- Timeout:
  - In RTS, SEND, ACK, or WAIT_IDLE, if the counter reaches TIMEOUT_CYC-1, force both oe=0, pulse err_timeout, and go to IDLE.
  - Timeout has priority over a same-cycle fall or completion.
- Result and status rules:
  - Exactly one of done, err_noack, err_timeout pulses per accepted byte.
  - busy deasserts in the same cycle as that pulse registers; tx_ready is 1 the next cycle.
- Counter: saturating at the terminal value; never wraps.
- Bit index: 4-bit; values above 9 are unreachable.
- Outputs are registered; no combinational path from inputs to oe.

Test Plan:
- Send 0xED; device model clocks 11 falls at 10 kHz and ACKs low → ps2_dat_oe values after falls 1..10 = 0,1,0,0,1,0,0,0,0(par=1),0; clk_oe high exactly 6000 cycles; done pulses once; busy low after.
- Send 0x00 → par=1; dat_oe=1 for falls 1..8, 0 at falls 9 and 10; done. Send 0xFF → par=1; dat_oe=0 for falls 1..10; done.
- Device leaves data high at the 11th fall → err_noack pulse, no done; both oe=0; tx_ready=1 next cycle.
- Device never clocks after RTS → err_timeout exactly 750000 cycles after clock release; dat_oe released in the same cycle as the pulse.
- Assert reset after fall 4 of a 0xF4 send → clk_oe=dat_oe=0 asynchronously; tx_ready=1; a new send of 0xF4 afterwards completes with done.
- Pulse tx_valid with 0x55 while busy sending 0xED → ignored; only the 0xED bits appear on the line; one done pulse total.
